id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register of the 5-stage MIPS core.
- Captures decode-stage control, operands and register specifiers each cycle, and presents them as the E-stage signals consumed by the hazard unit and execute stage: RsE, RtE, WriteRegE, MemtoRegE, RegWriteE.
- Honours the hazard unit's FlushE by inserting a bubble, and supports an E-stage hold.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- DATA_WIDTH, 32, operand and immediate width
- REG_ADDR_WIDTH, 5, register specifier width
- ALU_CTRL_WIDTH, 3, ALUControl width
- CNT_WIDTH, 16, bubble counter width

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- FlushE  input  1  from hazard unit; insert bubble at next edge
- StallE  input  1  hold E-stage contents (tie 0 if unused)
- ValidD  input  1  D-stage holds a real instruction
- RegWriteD  input  1  control
- MemtoRegD  input  1  control
- MemWriteD  input  1  control
- ALUSrcD  input  1  control
- RegDstD  input  1  control: 1 selects Rd, 0 selects Rt
- ALUControlD  input  ALU_CTRL_WIDTH  control
- RD1D, RD2D  input  DATA_WIDTH  register-file read data
- SignImmD  input  DATA_WIDTH  sign-extended immediate
- RsD, RtD, RdD  input  REG_ADDR_WIDTH  specifiers
- ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  output  1  registered controls
- ALUControlE  output  ALU_CTRL_WIDTH  registered control
- RD1E, RD2E, SignImmE  output  DATA_WIDTH  registered data
- RsE, RtE, RdE  output  REG_ADDR_WIDTH  registered specifiers
- WriteRegE  output  REG_ADDR_WIDTH  combinational: RegDstE ? RdE : RtE
- BubbleCount  output  CNT_WIDTH  number of bubbles inserted since reset

Behaviour:
- **Reset:** reset high clears every registered output and BubbleCount to 0 immediately, without waiting for clk. WriteRegE therefore reads 0. Reset asserted mid-operation discards the in-flight instruction; no partial state is retained.
- **Update priority per rising edge** (reset low), highest first:
  1. FlushE=1: bubble. ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE all go to 0. RsE, RtE, RdE go to 0 so no false forwarding or load-use match occurs. RD1E, RD2E, SignImmE go to 0. BubbleCount increments.
  2. StallE=1: all E registers hold; BubbleCount holds.
  3. Otherwise: every E register loads its D counterpart. ValidE loads ValidD. Controls pass through regardless of ValidD; the D stage guarantees zero controls when ValidD=0.
- **Simultaneous events:** FlushE and StallE together means flush wins and the bubble is inserted.
- **Latency:** exactly one cycle from D inputs to E outputs. There is no combinational path from any D input to any E output.
- **WriteRegE:** purely combinational from registered RegDstE, RdE and RtE. Width is REG_ADDR_WIDTH; no truncation.
- **BubbleCount:** increments by 1 per flush edge and saturates at all-ones. It does not wrap, and saturation is sticky until reset.
- **Outputs:** no X on any output after reset deassertion, regardless of D inputs being X only when FlushE=1.

Test Plan:
- **Reset:**
  - Stimulus: drive all D inputs nonzero (RsD=5, RtD=6, RdD=7, RegDstD=1), assert reset asynchronously between clock edges.
  - Response: all E outputs are 0 before the next edge; WriteRegE=0; BubbleCount=0.
- **Pass-through:**
  - Stimulus: RegWriteD=1, MemtoRegD=1, RsD=3, RtD=4, RdD=9, RegDstD=0, RD1D=0xDEADBEEF, ValidD=1; one edge.
  - Response: RegWriteE=1, MemtoRegE=1, RsE=3, RtE=4, WriteRegE=4, RD1E=0xDEADBEEF, ValidE=1. With RegDstD=1 on the next edge, WriteRegE=9.
- **Load-use flush:**
  - Stimulus: E holds a load (MemtoRegE=1, RtE=4); assert FlushE=1 for one edge with nonzero D inputs.
  - Response: all controls and specifiers are 0, ValidE=0, BubbleCount=1. The following unflushed edge loads D normally.
- **Stall hold:**
  - Stimulus: load RD2D=0x12345678, then StallE=1 for 3 edges while D inputs change.
  - Response: RD2E stays 0x12345678 and all E outputs are unchanged; BubbleCount is unchanged.
- **Flush over stall:**
  - Stimulus: FlushE=1 and StallE=1 on the same edge.
  - Response: bubble inserted (ValidE=0, RegWriteE=0, RsE=0), BubbleCount increments.
- **Counter saturation:**
  - Stimulus: CNT_WIDTH=4; apply 20 consecutive flush edges.
  - Response: BubbleCount reads 15 after the 15th flush and stays 15; reset returns it to 0.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Bundles the decode-to-execute pipeline register's signals.
//   Hazard controls : FlushE, StallE
//   D-stage inputs  : ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
//                     RegDstD, ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD
//   E-stage outputs : ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE,
//                     RegDstE, ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE,
//                     RdE, WriteRegE, BubbleCount
// master : drives the D side and hazard controls (decode stage / hazard unit)
// slave  : the pipeline register itself
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ALU_CTRL_WIDTH = 3,
   parameter int CNT_WIDTH      = 16
);
   logic                      FlushE;
   logic                      StallE;

   logic                      ValidD;
   logic                      RegWriteD;
   logic                      MemtoRegD;
   logic                      MemWriteD;
   logic                      ALUSrcD;
   logic                      RegDstD;
   logic [ALU_CTRL_WIDTH-1:0] ALUControlD;
   logic [DATA_WIDTH-1:0]     RD1D;
   logic [DATA_WIDTH-1:0]     RD2D;
   logic [DATA_WIDTH-1:0]     SignImmD;
   logic [REG_ADDR_WIDTH-1:0] RsD;
   logic [REG_ADDR_WIDTH-1:0] RtD;
   logic [REG_ADDR_WIDTH-1:0] RdD;

   logic                      ValidE;
   logic                      RegWriteE;
   logic                      MemtoRegE;
   logic                      MemWriteE;
   logic                      ALUSrcE;
   logic                      RegDstE;
   logic [ALU_CTRL_WIDTH-1:0] ALUControlE;
   logic [DATA_WIDTH-1:0]     RD1E;
   logic [DATA_WIDTH-1:0]     RD2E;
   logic [DATA_WIDTH-1:0]     SignImmE;
   logic [REG_ADDR_WIDTH-1:0] RsE;
   logic [REG_ADDR_WIDTH-1:0] RtE;
   logic [REG_ADDR_WIDTH-1:0] RdE;
   logic [REG_ADDR_WIDTH-1:0] WriteRegE;
   logic [CNT_WIDTH-1:0]      BubbleCount;

   modport master (
      output FlushE, StallE,
      output ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
      output ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
      input  ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
      input  ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE,
      input  WriteRegE, BubbleCount
   );

   modport slave (
      input  FlushE, StallE,
      input  ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
      input  ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
      output ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
      output ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE,
      output WriteRegE, BubbleCount
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// Decode-to-execute pipeline register of the 5-stage MIPS core.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high; clears all E state and BubbleCount
//   bus   : id_ex_pipe_reg_if.slave - D-stage inputs, FlushE/StallE,
//           registered E-stage outputs, WriteRegE and BubbleCount
// Per edge: FlushE inserts a bubble (everything zero, counter +1, saturating),
// otherwise StallE holds, otherwise the D stage is captured.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ALU_CTRL_WIDTH = 3,
   parameter int CNT_WIDTH      = 16
) (
   input logic               clk,
   input logic               reset,
   id_ex_pipe_reg_if.slave   bus
);

   typedef struct packed {
      logic                      valid;
      logic                      reg_write;
      logic                      mem_to_reg;
      logic                      mem_write;
      logic                      alu_src;
      logic                      reg_dst;
      logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
      logic [DATA_WIDTH-1:0]     rd1;
      logic [DATA_WIDTH-1:0]     rd2;
      logic [DATA_WIDTH-1:0]     sign_imm;
      logic [REG_ADDR_WIDTH-1:0] rs;
      logic [REG_ADDR_WIDTH-1:0] rt;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } e_stage_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   e_stage_t             e_q, e_d;
   logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

   // Next-state selection: flush beats stall, stall beats capture.
   always_comb begin
      e_d          = e_q;
      bubble_cnt_d = bubble_cnt_q;
      if (bus.FlushE) begin
         // Zeroed specifiers keep the hazard unit from matching a bubble.
         e_d = '0;
         if (bubble_cnt_q == CNT_MAX) begin
            bubble_cnt_d = bubble_cnt_q;
         end else begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
         end
      end else if (bus.StallE) begin
         e_d = e_q;
      end else begin
         e_d.valid      = bus.ValidD;
         e_d.reg_write  = bus.RegWriteD;
         e_d.mem_to_reg = bus.MemtoRegD;
         e_d.mem_write  = bus.MemWriteD;
         e_d.alu_src    = bus.ALUSrcD;
         e_d.reg_dst    = bus.RegDstD;
         e_d.alu_ctrl   = bus.ALUControlD;
         e_d.rd1        = bus.RD1D;
         e_d.rd2        = bus.RD2D;
         e_d.sign_imm   = bus.SignImmD;
         e_d.rs         = bus.RsD;
         e_d.rt         = bus.RtD;
         e_d.rd         = bus.RdD;
      end
   end

   // E-stage state and bubble counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q          <= '0;
         bubble_cnt_q <= {CNT_WIDTH{1'b0}};
      end else begin
         e_q          <= e_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.ValidE      = e_q.valid;
   assign bus.RegWriteE   = e_q.reg_write;
   assign bus.MemtoRegE   = e_q.mem_to_reg;
   assign bus.MemWriteE   = e_q.mem_write;
   assign bus.ALUSrcE     = e_q.alu_src;
   assign bus.RegDstE     = e_q.reg_dst;
   assign bus.ALUControlE = e_q.alu_ctrl;
   assign bus.RD1E        = e_q.rd1;
   assign bus.RD2E        = e_q.rd2;
   assign bus.SignImmE    = e_q.sign_imm;
   assign bus.RsE         = e_q.rs;
   assign bus.RtE         = e_q.rt;
   assign bus.RdE         = e_q.rd;
   assign bus.BubbleCount = bubble_cnt_q;

   // Destination mux works only on registered state, so D never reaches E.
   assign bus.WriteRegE   = e_q.reg_dst ? e_q.rd : e_q.rt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Directed scenarios followed by randomized flush/stall/capture traffic,
// checked against a record-level reference model of the E stage.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 3;
   localparam int NW = 4;
   localparam int CNT_SAT = (1 << NW) - 1;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   id_ex_pipe_reg_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
                       .ALU_CTRL_WIDTH(CW), .CNT_WIDTH(NW)) bus ();

   id_ex_pipe_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
                    .ALU_CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic          valid;
      logic          rw;
      logic          m2r;
      logic          mw;
      logic          asrc;
      logic          rdst;
      logic [CW-1:0] aluc;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] imm;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
   } rec_t;

   rec_t d;        // what the bench presents on the D side
   rec_t exp_e;    // what the E stage should hold
   int   exp_cnt;  // bubbles inserted since reset, saturating
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_d();
      bus.ValidD      = d.valid;
      bus.RegWriteD   = d.rw;
      bus.MemtoRegD   = d.m2r;
      bus.MemWriteD   = d.mw;
      bus.ALUSrcD     = d.asrc;
      bus.RegDstD     = d.rdst;
      bus.ALUControlD = d.aluc;
      bus.RD1D        = d.rd1;
      bus.RD2D        = d.rd2;
      bus.SignImmD    = d.imm;
      bus.RsD         = d.rs;
      bus.RtD         = d.rt;
      bus.RdD         = d.rd;
   endtask

   task automatic rand_d();
      d.valid = 1'($urandom_range(0, 3) != 0);
      d.rw    = 1'($urandom);
      d.m2r   = 1'($urandom);
      d.mw    = 1'($urandom);
      d.asrc  = 1'($urandom);
      d.rdst  = 1'($urandom);
      d.aluc  = CW'($urandom);
      d.rd1   = $urandom;
      d.rd2   = $urandom;
      d.imm   = $urandom;
      d.rs    = AW'($urandom);
      d.rt    = AW'($urandom);
      d.rd    = AW'($urandom);
      // An invalid D slot carries no control.
      if (!d.valid) begin
         d.rw = 1'b0; d.m2r = 1'b0; d.mw = 1'b0; d.asrc = 1'b0; d.rdst = 1'b0;
         d.aluc = '0;
      end
   endtask

   task automatic check_all(input string tag);
      logic [AW-1:0] exp_wreg;
      exp_wreg = exp_e.rdst ? exp_e.rd : exp_e.rt;
      chk({tag, ".ValidE"},      64'(bus.ValidE),      64'(exp_e.valid));
      chk({tag, ".RegWriteE"},   64'(bus.RegWriteE),   64'(exp_e.rw));
      chk({tag, ".MemtoRegE"},   64'(bus.MemtoRegE),   64'(exp_e.m2r));
      chk({tag, ".MemWriteE"},   64'(bus.MemWriteE),   64'(exp_e.mw));
      chk({tag, ".ALUSrcE"},     64'(bus.ALUSrcE),     64'(exp_e.asrc));
      chk({tag, ".RegDstE"},     64'(bus.RegDstE),     64'(exp_e.rdst));
      chk({tag, ".ALUControlE"}, 64'(bus.ALUControlE), 64'(exp_e.aluc));
      chk({tag, ".RD1E"},        64'(bus.RD1E),        64'(exp_e.rd1));
      chk({tag, ".RD2E"},        64'(bus.RD2E),        64'(exp_e.rd2));
      chk({tag, ".SignImmE"},    64'(bus.SignImmE),    64'(exp_e.imm));
      chk({tag, ".RsE"},         64'(bus.RsE),         64'(exp_e.rs));
      chk({tag, ".RtE"},         64'(bus.RtE),         64'(exp_e.rt));
      chk({tag, ".RdE"},         64'(bus.RdE),         64'(exp_e.rd));
      chk({tag, ".WriteRegE"},   64'(bus.WriteRegE),   64'(exp_wreg));
      chk({tag, ".BubbleCount"}, 64'(bus.BubbleCount), 64'(exp_cnt));
   endtask

   // One clock edge with the given hazard controls; the model follows the
   // flush > stall > capture rule, then everything is compared.
   task automatic step(input string tag, input logic fl, input logic st);
      bus.FlushE = fl;
      bus.StallE = st;
      drive_d();
      @(posedge clk);
      if (fl) begin
         exp_e = '0;
         if (exp_cnt < CNT_SAT) exp_cnt++;
      end else if (!st) begin
         exp_e = d;
      end
      #1;
      check_all(tag);
   endtask

   // Reset asserted between edges must clear outputs before the next edge.
   task automatic async_reset(input string tag);
      #3;
      reset = 1'b1;
      #1;
      exp_e   = '0;
      exp_cnt = 0;
      check_all(tag);
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.FlushE = 1'b0;
      bus.StallE = 1'b0;
      d = '0;
      drive_d();
      exp_e = '0;
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all("init");
      @(negedge clk);
      reset = 1'b0;

      // Pass-through with Rt then Rd as destination.
      d = '0;
      d.valid = 1'b1; d.rw = 1'b1; d.m2r = 1'b1;
      d.rs = 5'd3; d.rt = 5'd4; d.rd = 5'd9; d.rdst = 1'b0;
      d.rd1 = 32'hDEADBEEF;
      step("pass", 1'b0, 1'b0);
      chk("pass.wreg_rt", 64'(bus.WriteRegE), 64'd4);
      chk("pass.rd1",     64'(bus.RD1E),      64'hDEADBEEF);
      d.rdst = 1'b1;
      step("pass2", 1'b0, 1'b0);
      chk("pass.wreg_rd", 64'(bus.WriteRegE), 64'd9);

      // Load-use bubble.
      d = '0;
      d.valid = 1'b1; d.rw = 1'b1; d.m2r = 1'b1; d.rt = 5'd4; d.rs = 5'd2;
      step("load", 1'b0, 1'b0);
      rand_d();
      d.valid = 1'b1; d.rw = 1'b1; d.rs = 5'd4;
      step("flush", 1'b1, 1'b0);
      chk("flush.cnt",  64'(bus.BubbleCount), 64'd1);
      chk("flush.m2r",  64'(bus.MemtoRegE),   64'd0);
      chk("flush.rt",   64'(bus.RtE),         64'd0);
      rand_d();
      step("after_flush", 1'b0, 1'b0);

      // Stall hold for three edges while D keeps changing.
      rand_d();
      d.rd2 = 32'h12345678;
      step("stall_load", 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         rand_d();
         step("stall", 1'b0, 1'b1);
         chk("stall.rd2", 64'(bus.RD2E),        64'h12345678);
         chk("stall.cnt", 64'(bus.BubbleCount), 64'd1);
      end

      // Flush and stall together: flush wins.
      rand_d();
      d.valid = 1'b1; d.rw = 1'b1; d.rs = 5'd7;
      step("flush_stall", 1'b1, 1'b1);
      chk("fs.valid", 64'(bus.ValidE),      64'd0);
      chk("fs.rs",    64'(bus.RsE),         64'd0);
      chk("fs.cnt",   64'(bus.BubbleCount), 64'd2);

      // Asynchronous reset with nonzero D inputs in flight.
      d = '0;
      d.valid = 1'b1; d.rw = 1'b1; d.rdst = 1'b1;
      d.rs = 5'd5; d.rt = 5'd6; d.rd = 5'd7; d.rd1 = 32'h1; d.imm = 32'h3;
      step("pre_rst", 1'b0, 1'b0);
      async_reset("async_rst");
      chk("rst.wreg", 64'(bus.WriteRegE), 64'd0);

      // Counter saturation at all-ones for a 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         rand_d();
         step("sat", 1'b1, 1'b0);
         if (i == 14) chk("sat.at15", 64'(bus.BubbleCount), 64'd15);
      end
      chk("sat.final", 64'(bus.BubbleCount), 64'd15);
      rand_d();
      step("sat_hold", 1'b0, 1'b0);
      async_reset("sat_rst");
      chk("sat.rst_cnt", 64'(bus.BubbleCount), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         rand_d();
         step("rand", 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
